// File: rtl/register_file_arbiter_if.sv
// Register file arbiter bus: two requester ports plus the register file port.
//   slave  : the arbiter's view (takes requests and rf responses, drives
//            completions, rf commands and busy)
//   master : the environment's view (requesters and the register file)
interface register_file_arbiter_if;
    logic        req0_valid;
    logic        req0_write;
    logic [1:0]  req0_address;
    logic [31:0] req0_write_data;
    logic        req0_done;
    logic        req0_error;
    logic [31:0] req0_read_data;

    logic        req1_valid;
    logic        req1_write;
    logic [1:0]  req1_address;
    logic [31:0] req1_write_data;
    logic        req1_done;
    logic        req1_error;
    logic [31:0] req1_read_data;

    logic        rf_write_enable;
    logic        rf_read_enable;
    logic [1:0]  rf_address;
    logic [31:0] rf_write_data;
    logic [31:0] rf_read_data;
    logic        rf_ready;

    logic        busy;

    modport slave (
        input  req0_valid, req0_write, req0_address, req0_write_data,
        input  req1_valid, req1_write, req1_address, req1_write_data,
        input  rf_read_data, rf_ready,
        output req0_done, req0_error, req0_read_data,
        output req1_done, req1_error, req1_read_data,
        output rf_write_enable, rf_read_enable, rf_address, rf_write_data,
        output busy
    );

    modport master (
        output req0_valid, req0_write, req0_address, req0_write_data,
        output req1_valid, req1_write, req1_address, req1_write_data,
        output rf_read_data, rf_ready,
        input  req0_done, req0_error, req0_read_data,
        input  req1_done, req1_error, req1_read_data,
        input  rf_write_enable, rf_read_enable, rf_address, rf_write_data,
        input  busy
    );
endinterface

// File: rtl/register_file_arbiter.sv
// Two-requester round-robin arbiter in front of a single-ported register file.
// One transaction at a time: IDLE (grant) -> ISSUE (one-cycle strobe) ->
// WAIT (rf_ready or timeout) -> DONE (one-cycle completion pulse).
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : requester / register file signals (slave modport)
// Parameter:
//   TIMEOUT_CYCLES : WAIT cycles without rf_ready before aborting (2..255)
module register_file_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    register_file_arbiter_if.slave       bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        gnt_q, gnt_d;
    logic        wr_q, wr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        rf_we_q, rf_we_d;
    logic        rf_re_q, rf_re_d;
    logic [1:0]  rf_addr_q, rf_addr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        done0_q, done0_d, done1_q, done1_d;
    logic        err0_q, err0_d, err1_q, err1_d;
    logic [31:0] rd0_q, rd0_d, rd1_q, rd1_d;

    logic        grant;
    logic [31:0] rd_val;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        wr_d         = wr_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        rf_addr_d    = rf_addr_q;
        rf_wdata_d   = rf_wdata_q;
        // Strobes and completion outputs are pulses: low unless set below.
        rf_we_d      = 1'b0;
        rf_re_d      = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        rd0_d        = '0;
        rd1_d        = '0;
        grant        = 1'b0;
        rd_val       = wr_q ? 32'd0 : bus.rf_read_data;

        case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    // Tie goes to whoever was not served last.
                    grant        = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q
                                                                      : bus.req1_valid;
                    gnt_d        = grant;
                    last_grant_d = grant;
                    wr_d         = grant ? bus.req1_write : bus.req0_write;
                    rf_addr_d    = grant ? bus.req1_address : bus.req0_address;
                    rf_wdata_d   = grant ? bus.req1_write_data : bus.req0_write_data;
                    rf_we_d      = wr_d;
                    rf_re_d      = ~wr_d;
                    busy_d       = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.rf_ready || (cnt_q == TMO_LAST)) begin
                    // rf_ready wins over a timeout landing in the same cycle.
                    state_d    = DONE;
                    done0_d    = ~gnt_q;
                    done1_d    = gnt_q;
                    err0_d     = ~gnt_q & ~bus.rf_ready;
                    err1_d     = gnt_q & ~bus.rf_ready;
                    rd0_d      = (~gnt_q & bus.rf_ready) ? rd_val : 32'd0;
                    rd1_d      = (gnt_q & bus.rf_ready) ? rd_val : 32'd0;
                    rf_addr_d  = '0;
                    rf_wdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            wr_q         <= 1'b0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_re_q      <= 1'b0;
            rf_addr_q    <= '0;
            rf_wdata_q   <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rd0_q        <= '0;
            rd1_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            wr_q         <= wr_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            rf_we_q      <= rf_we_d;
            rf_re_q      <= rf_re_d;
            rf_addr_q    <= rf_addr_d;
            rf_wdata_q   <= rf_wdata_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rd0_q        <= rd0_d;
            rd1_q        <= rd1_d;
        end
    end

    assign bus.busy            = busy_q;
    assign bus.rf_write_enable = rf_we_q;
    assign bus.rf_read_enable  = rf_re_q;
    assign bus.rf_address      = rf_addr_q;
    assign bus.rf_write_data   = rf_wdata_q;
    assign bus.req0_done       = done0_q;
    assign bus.req0_error      = err0_q;
    assign bus.req0_read_data  = rd0_q;
    assign bus.req1_done       = done1_q;
    assign bus.req1_error      = err1_q;
    assign bus.req1_read_data  = rd1_q;
endmodule
